axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
// PURPOSE
//  AXI4 responder (slave) with the same AW/W/B/AR/R port set as the DDR3 core's AXI port.
//  Backed by an on-chip register array; supports INCR bursts.
//  Stands in for the DDR3 core so AXI initiators can be brought up and regressed without PHY/DDR3 models.
//  Write and read paths are independent, each with one outstanding transaction.
// PARAMETERS
//  DATA_WIDTH      32  AXI data width, bits (multiple of 8); MASKS = DATA_WIDTH/8
//  ADDR_WIDTH      27  AXI byte-address width
//  ID_WIDTH        4   AXI transaction-ID width
//  MEM_WORDS_LOG2  8   log2 of array depth in DATA_WIDTH words
// PORTS
//  clock          in   1           system clock
//  reset          in   1           synchronous, active-high reset
//  axi_awvalid_i  in   1           write-address valid
//  axi_awready_o  out  1           write-address ready
//  axi_awaddr_i   in   ADDR_WIDTH  write byte address
//  axi_awid_i     in   ID_WIDTH    write ID
//  axi_awlen_i    in   8           beats minus one
//  axi_awburst_i  in   2           burst type; only 2'b01 (INCR) is legal
//  axi_wvalid_i   in   1           write-data valid
//  axi_wready_o   out  1           write-data ready
//  axi_wlast_i    in   1           final write beat
//  axi_wstrb_i    in   MASKS       byte strobes
//  axi_wdata_i    in   DATA_WIDTH  write data
//  axi_bvalid_o   out  1           write-response valid
//  axi_bready_i   in   1           write-response ready
//  axi_bresp_o    out  2           2'b00 OKAY, 2'b10 SLVERR
//  axi_bid_o      out  ID_WIDTH    echoed AWID
//  axi_arvalid_i  in   1           read-address valid
//  axi_arready_o  out  1           read-address ready
//  axi_araddr_i   in   ADDR_WIDTH  read byte address
//  axi_arid_i     in   ID_WIDTH    read ID
//  axi_arlen_i    in   8           beats minus one
//  axi_arburst_i  in   2           burst type
//  axi_rvalid_o   out  1           read-data valid
//  axi_rready_i   in   1           read-data ready
//  axi_rlast_o    out  1           final read beat
//  axi_rresp_o    out  2           read response
//  axi_rid_o      out  ID_WIDTH    echoed ARID
//  axi_rdata_o    out  DATA_WIDTH  read data
// BEHAVIOUR
//  Reset and outputs:
//   - While reset is high, every output is 0 (data, ID and resp included); both FSMs go to IDLE.
//   - Array contents are not cleared.
//   - All outputs are registered. Reset mid-burst aborts the burst; no response is issued.
//  Addressing:
//   - word = addr[log2(MASKS) +: MEM_WORDS_LOG2]; unaligned low bits are ignored.
//   - The word address increments per beat, modulo 2**MEM_WORDS_LOG2 (wraps).
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: awready=1. On AW handshake at cycle N: latch ID, len, word and burst-ok; go W_DATA; wready=1 from N+1.
//   - W_DATA: each W handshake writes the bytes enabled by wstrb to the current word (only if burst-ok), then increments.
//   - The burst ends on wlast, regardless of awlen. Go W_RESP; bvalid=1 the next cycle.
//   - bresp=2'b10 if awburst != 2'b01 or the beat count != awlen+1; otherwise 2'b00.
//   - W_RESP: bvalid, bid and bresp are held until bready; then W_IDLE (awready=1 the next cycle).
//  Read FSM R_IDLE -> R_LOAD -> R_DATA -> R_IDLE:
//   - R_IDLE: arready=1. On AR handshake at cycle N: go R_LOAD; rdata is registered from the array.
//   - First rvalid is at N+2.
//   - R_DATA: while rvalid && !rready, rdata, rlast, rid and rresp hold stable.
//   - On rvalid && rready, the next word loads in the same cycle, giving back-to-back beats at full rate.
//   - rlast=1 on beat arlen+1. The handshake on that beat returns to R_IDLE (arready=1 the next cycle).
//   - rresp=2'b10 on every beat if arburst != 2'b01 (array data still returned); otherwise 2'b00.
//  Simultaneous events:
//   - AW and AR may be accepted in the same cycle.
//   - A write beat and a read load to the same word in the same cycle: the read returns the pre-write value.
//  Handshakes: AXI rules apply; valid never depends on ready; no combinational path from any input to any output.
// TESTING
//  1. Write addr 0, awlen 3, awid 2, wstrb f, data D0..D3 -> bvalid with bid=2, bresp=00.
//     Then read addr 0, arlen 3, arid 5 -> D0..D3, rid=5, rlast on beat 4 only, first rvalid 2 cycles after AR.
//  2. Word 4 (addr 16) holds 32'h11223344; write 32'hAABBCCDD with wstrb 4'b0101 -> read returns 32'h11BB33DD.
//  3. rready pattern 1,0,1,0 during a 4-beat read -> outputs stable while stalled, exactly 4 beats.
//     bready low 5 cycles -> bvalid held and awready=0 throughout.
//  4. Write at word 254, awlen 3 -> words 254,255,0,1 written; 4-beat read from word 254 returns the same data.
//  5. awlen 3 with wlast on beat 2 -> bresp=2'b10.
//     arburst 2'b00 -> rresp=2'b10 on all beats.
//  6. Assert reset after 2 of 4 read beats -> rvalid=0 the next cycle; arready=1 the first cycle after reset falls.
//     Earlier written data is still readable.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by an on-chip register array, standing in for the DDR3 core's AXI port.
// Independent write and read FSMs, one outstanding transaction each, INCR bursts with word-address wrap.
module axi_sram_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 27,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_WORDS_LOG2 = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [ID_WIDTH-1:0]     axi_awid_i,
    input  logic [7:0]              axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    input  logic                    axi_wlast_i,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    output logic [1:0]              axi_bresp_o,
    output logic [ID_WIDTH-1:0]     axi_bid_o,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [ID_WIDTH-1:0]     axi_arid_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic                    axi_rlast_o,
    output logic [1:0]              axi_rresp_o,
    output logic [ID_WIDTH-1:0]     axi_rid_o,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o,
    output logic [1:0]              dbg_w_state_o,
    output logic [1:0]              dbg_r_state_o
);
    // Handshake rule on every channel: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid never waits for ready, and every output here is a flop.

    localparam int MASKS = DATA_WIDTH / 8;
    localparam int OFFS  = (MASKS > 1) ? $clog2(MASKS) : 0;
    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    localparam logic [MEM_WORDS_LOG2-1:0] WORD_ONE = 1;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_DATA = 2'd2} r_state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    w_state_t                  w_state_q, w_state_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]       bid_q, bid_d;
    logic [ID_WIDTH-1:0]       w_id_q, w_id_d;
    logic [7:0]                w_len_q, w_len_d;
    logic [MEM_WORDS_LOG2-1:0] w_word_q, w_word_d;
    logic                      w_ok_q, w_ok_d;
    logic [8:0]                w_cnt_q, w_cnt_d;
    logic                      mem_we;

    r_state_t                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rlast_q, rlast_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [ID_WIDTH-1:0]       rid_q, rid_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]       r_id_q, r_id_d;
    logic [7:0]                r_len_q, r_len_d;
    logic [MEM_WORDS_LOG2-1:0] r_word_q, r_word_d;
    logic                      r_ok_q, r_ok_d;
    logic [7:0]                r_cnt_q, r_cnt_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_word_d  = w_word_q;
        w_ok_d    = w_ok_q;
        w_cnt_d   = w_cnt_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi_awvalid_i && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_id_d    = axi_awid_i;
                    w_len_d   = axi_awlen_i;
                    w_word_d  = axi_awaddr_i[OFFS +: MEM_WORDS_LOG2];
                    w_ok_d    = (axi_awburst_i == 2'b01);
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid_i && wready_q) begin
                    mem_we   = w_ok_q;
                    w_word_d = w_word_q + WORD_ONE;
                    // Saturate so an overlong burst can never alias back onto awlen+1.
                    w_cnt_d  = (&w_cnt_q) ? w_cnt_q : w_cnt_q + 9'd1;
                    if (axi_wlast_i) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = (w_ok_q && (w_cnt_q == {1'b0, w_len_q})) ? 2'b00 : 2'b10;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready_i) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_word_d  = r_word_q;
        r_ok_d    = r_ok_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid_i && arready_q) begin
                    arready_d = 1'b0;
                    r_id_d    = axi_arid_i;
                    r_len_d   = axi_arlen_i;
                    r_word_d  = axi_araddr_i[OFFS +: MEM_WORDS_LOG2];
                    r_ok_d    = (axi_arburst_i == 2'b01);
                    r_state_d = R_LOAD;
                end
            end
            R_LOAD: begin
                rvalid_d  = 1'b1;
                rdata_d   = mem_q[r_word_q];
                rlast_d   = (r_len_q == 8'd0);
                rid_d     = r_id_q;
                rresp_d   = r_ok_q ? 2'b00 : 2'b10;
                r_word_d  = r_word_q + WORD_ONE;
                r_cnt_d   = 8'd1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid_q && axi_rready_i) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        // Reads the array before this edge's write lands, so a colliding beat sees old data.
                        rdata_d  = mem_q[r_word_q];
                        rlast_d  = (r_cnt_q == r_len_q);
                        r_word_d = r_word_q + WORD_ONE;
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_word_q  <= '0;
            w_ok_q    <= 1'b0;
            w_cnt_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            rdata_q   <= '0;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_word_q  <= '0;
            r_ok_q    <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_word_q  <= w_word_d;
            w_ok_q    <= w_ok_d;
            w_cnt_q   <= w_cnt_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_word_q  <= r_word_d;
            r_ok_q    <= r_ok_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Array is never cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int b = 0; b < MASKS; b++) begin
                if (axi_wstrb_i[b]) begin
                    mem_q[w_word_q][8*b +: 8] <= axi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign axi_awready_o = awready_q;
    assign axi_wready_o  = wready_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_bid_o     = bid_q;
    assign axi_arready_o = arready_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rlast_o   = rlast_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rid_o     = rid_q;
    assign axi_rdata_o   = rdata_q;
    assign dbg_w_state_o = w_state_q;
    assign dbg_r_state_o = r_state_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: bursts, strobes, back-pressure, wrap, error responses, reset abort.
module tb_axi_sram_responder;

    logic        clock;
    logic        reset;
    logic        axi_awvalid_i;
    logic        axi_awready_o;
    logic [26:0] axi_awaddr_i;
    logic [3:0]  axi_awid_i;
    logic [7:0]  axi_awlen_i;
    logic [1:0]  axi_awburst_i;
    logic        axi_wvalid_i;
    logic        axi_wready_o;
    logic        axi_wlast_i;
    logic [3:0]  axi_wstrb_i;
    logic [31:0] axi_wdata_i;
    logic        axi_bvalid_o;
    logic        axi_bready_i;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i;
    logic        axi_arready_o;
    logic [26:0] axi_araddr_i;
    logic [3:0]  axi_arid_i;
    logic [7:0]  axi_arlen_i;
    logic [1:0]  axi_arburst_i;
    logic        axi_rvalid_o;
    logic        axi_rready_i;
    logic        axi_rlast_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic [1:0]  dbg_w_state_o;
    logic [1:0]  dbg_r_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wbuf [0:7];

    axi_sram_responder dut (
        .clock(clock), .reset(reset),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
        .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wlast_i(axi_wlast_i),
        .axi_wstrb_i(axi_wstrb_i), .axi_wdata_i(axi_wdata_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bresp_o(axi_bresp_o),
        .axi_bid_o(axi_bid_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
        .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .axi_rlast_o(axi_rlast_o),
        .axi_rresp_o(axi_rresp_o), .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o),
        .dbg_w_state_o(dbg_w_state_o), .dbg_r_state_o(dbg_r_state_o)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drivers: inputs change and outputs are sampled on the falling edge.
    task automatic do_write(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int bstall);
        int t;
        axi_awvalid_i = 1'b1;
        axi_awaddr_i  = addr;
        axi_awid_i    = id;
        axi_awlen_i   = len;
        axi_awburst_i = burst;
        t = 0;
        while (!axi_awready_o && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("aw_ready", axi_awready_o, 1);
        @(negedge clock);
        axi_awvalid_i = 1'b0;
        check("w_ready_after_aw", axi_wready_o, 1);
        check("aw_ready_low_in_burst", axi_awready_o, 0);
        for (int b = 0; b < nbeats; b++) begin
            axi_wvalid_i = 1'b1;
            axi_wdata_i  = wbuf[b];
            axi_wstrb_i  = strb;
            axi_wlast_i  = (b == nbeats - 1);
            t = 0;
            while (!axi_wready_o && t < 50) begin
                @(negedge clock);
                t++;
            end
            check("w_ready_beat", axi_wready_o, 1);
            @(negedge clock);
        end
        axi_wvalid_i = 1'b0;
        axi_wlast_i  = 1'b0;
        check("b_valid_next", axi_bvalid_o, 1);
        check("b_id", axi_bid_o, id);
        check("b_resp", axi_bresp_o, exp_resp);
        for (int s = 0; s < bstall; s++) begin
            @(negedge clock);
            check("b_hold_valid", axi_bvalid_o, 1);
            check("b_hold_awready", axi_awready_o, 0);
            check("b_hold_resp", axi_bresp_o, exp_resp);
        end
        axi_bready_i = 1'b1;
        @(negedge clock);
        axi_bready_i = 1'b0;
        check("b_valid_drop", axi_bvalid_o, 0);
        check("aw_ready_after_b", axi_awready_o, 1);
    endtask

    // mode 0: rready always high; mode 1: rready 1,0,1,0... per cycle. abort_after>0 stops after that many beats.
    task automatic do_read(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] exp_resp, input int mode,
                           input int abort_after);
        int t, beats, cyc, want;
        logic rr, stalled;
        logic [31:0] s_data, e_data;
        logic s_last;
        axi_arvalid_i = 1'b1;
        axi_araddr_i  = addr;
        axi_arid_i    = id;
        axi_arlen_i   = len;
        axi_arburst_i = burst;
        t = 0;
        while (!axi_arready_o && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("ar_ready", axi_arready_o, 1);
        @(negedge clock);
        axi_arvalid_i = 1'b0;
        check("r_valid_n1", axi_rvalid_o, 0);
        @(negedge clock);
        check("r_valid_n2", axi_rvalid_o, 1);
        want = (abort_after > 0) ? abort_after : int'(len) + 1;
        beats = 0;
        cyc = 0;
        stalled = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        while (beats < want && cyc < 600) begin
            rr = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            axi_rready_i = rr;
            if (stalled) begin
                check("r_hold_valid", axi_rvalid_o, 1);
                check("r_hold_data", axi_rdata_o, s_data);
                check("r_hold_last", axi_rlast_o, s_last);
                check("r_hold_id", axi_rid_o, id);
                check("r_hold_resp", axi_rresp_o, exp_resp);
                stalled = 1'b0;
            end
            if (axi_rvalid_o) begin
                if (rr) begin
                    e_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                    check("r_data", axi_rdata_o, e_data);
                    check("r_id", axi_rid_o, id);
                    check("r_resp", axi_rresp_o, exp_resp);
                    check("r_last", axi_rlast_o, (beats == int'(len)));
                    beats++;
                end else begin
                    s_data  = axi_rdata_o;
                    s_last  = axi_rlast_o;
                    stalled = 1'b1;
                end
            end
            if (beats < want) begin
                @(negedge clock);
                cyc++;
            end
        end
        check("r_beats", beats, want);
        if (abort_after == 0) begin
            @(negedge clock);
            axi_rready_i = 1'b0;
            check("r_valid_end", axi_rvalid_o, 0);
            check("ar_ready_end", axi_arready_o, 1);
        end else begin
            axi_rready_i = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        axi_awvalid_i = 0; axi_awaddr_i = 0; axi_awid_i = 0; axi_awlen_i = 0; axi_awburst_i = 0;
        axi_wvalid_i = 0; axi_wlast_i = 0; axi_wstrb_i = 0; axi_wdata_i = 0; axi_bready_i = 0;
        axi_arvalid_i = 0; axi_araddr_i = 0; axi_arid_i = 0; axi_arlen_i = 0; axi_arburst_i = 0;
        axi_rready_i = 0;
        repeat (3) @(negedge clock);
        check("rst_awready", axi_awready_o, 0);
        check("rst_arready", axi_arready_o, 0);
        check("rst_outs", {axi_wready_o, axi_bvalid_o, axi_bresp_o, axi_bid_o, axi_rvalid_o,
                           axi_rlast_o, axi_rresp_o, axi_rid_o}, 0);
        check("rst_rdata", axi_rdata_o, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_awready", axi_awready_o, 1);
        check("post_rst_arready", axi_arready_o, 1);

        // Four-beat write then read-back from word 0
        wbuf[0] = 32'h0123_4567; wbuf[1] = 32'h89AB_CDEF; wbuf[2] = 32'hDEAD_BEEF; wbuf[3] = 32'hCAFE_F00D;
        do_write(27'd0, 4'd2, 8'd3, 2'b01, 4, 4'hF, 2'b00, 0);
        exp_q.push_back(32'h0123_4567); exp_q.push_back(32'h89AB_CDEF);
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hCAFE_F00D);
        do_read(27'd0, 4'd5, 8'd3, 2'b01, 2'b00, 0, 0);

        // Partial strobes on word 4
        wbuf[0] = 32'h1122_3344;
        do_write(27'd16, 4'd1, 8'd0, 2'b01, 1, 4'hF, 2'b00, 0);
        wbuf[0] = 32'hAABB_CCDD;
        do_write(27'd16, 4'd3, 8'd0, 2'b01, 1, 4'b0101, 2'b00, 0);
        exp_q.push_back(32'h11BB_33DD);
        do_read(27'd16, 4'd9, 8'd0, 2'b01, 2'b00, 0, 0);

        // Read back-pressure, then write-response back-pressure
        exp_q.push_back(32'h0123_4567); exp_q.push_back(32'h89AB_CDEF);
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hCAFE_F00D);
        do_read(27'd0, 4'd6, 8'd3, 2'b01, 2'b00, 1, 0);
        wbuf[0] = 32'h5555_0001; wbuf[1] = 32'h5555_0002;
        do_write(27'd32, 4'd12, 8'd1, 2'b01, 2, 4'hF, 2'b00, 5);
        exp_q.push_back(32'h5555_0001); exp_q.push_back(32'h5555_0002);
        do_read(27'd32, 4'd12, 8'd1, 2'b01, 2'b00, 0, 0);

        // Early wlast and non-INCR read
        wbuf[0] = 32'hA0A0_A0A0; wbuf[1] = 32'hA1A1_A1A1;
        do_write(27'd256, 4'd4, 8'd3, 2'b01, 2, 4'hF, 2'b10, 0);
        exp_q.push_back(32'h0123_4567); exp_q.push_back(32'h89AB_CDEF);
        do_read(27'd0, 4'd7, 8'd1, 2'b00, 2'b10, 0, 0);

        // Reset in the middle of a read burst
        exp_q.push_back(32'h0123_4567); exp_q.push_back(32'h89AB_CDEF);
        do_read(27'd0, 4'd8, 8'd3, 2'b01, 2'b00, 0, 2);
        reset = 1'b1;
        @(negedge clock);
        check("abort_rvalid", axi_rvalid_o, 0);
        check("abort_arready", axi_arready_o, 0);
        check("abort_rdata", axi_rdata_o, 0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_arready_after", axi_arready_o, 1);
        check("abort_awready_after", axi_awready_o, 1);
        exp_q.push_back(32'h0123_4567); exp_q.push_back(32'h89AB_CDEF);
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hCAFE_F00D);
        do_read(27'd0, 4'd10, 8'd3, 2'b01, 2'b00, 0, 0);

        // Wrap from word 254 through 255, 0, 1
        wbuf[0] = 32'hE000_0000; wbuf[1] = 32'hE111_1111; wbuf[2] = 32'hE222_2222; wbuf[3] = 32'hE333_3333;
        do_write(27'd1016, 4'd7, 8'd3, 2'b01, 4, 4'hF, 2'b00, 0);
        exp_q.push_back(32'hE000_0000); exp_q.push_back(32'hE111_1111);
        exp_q.push_back(32'hE222_2222); exp_q.push_back(32'hE333_3333);
        do_read(27'd1016, 4'd11, 8'd3, 2'b01, 2'b00, 0, 0);
        exp_q.push_back(32'hE222_2222); exp_q.push_back(32'hE333_3333);
        do_read(27'd0, 4'd13, 8'd1, 2'b01, 2'b00, 0, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
